// File: rtl/sync_symbol_mapper.sv
// BPSK sync-symbol mapper: snapshots the sync word on start and streams one {Q,I} sample per used carrier.
// Optional build macro SYNC_MAPPER_REPEAT_EN emits the symbol twice back-to-back (Schmidl-Cox timing).
module sync_symbol_mapper #(
  parameter int unsigned        USED_CARRIERS      = 800,
  parameter int unsigned        SYNC_WORD_WIDTH    = 800,
  parameter logic signed [15:0] AMPLITUDE          = 16'sd8192,
  parameter int unsigned        M_AXIS_TDATA_WIDTH = 32
) (
  input  logic                          m_axis_data_aclk,
  input  logic                          m_axis_data_aresetn,
  input  logic [SYNC_WORD_WIDTH-1:0]    sync_word,
  input  logic                          sync_word_ready,
  input  logic                          start,
  output logic                          busy,
  output logic                          start_err,
  output logic                          m_axis_data_tvalid,
  input  logic                          m_axis_data_tready,
  output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_data_tdata,
  output logic                          m_axis_data_tlast
);

  localparam int unsigned     CNT_W  = 11;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(USED_CARRIERS - 1);

  // pass_q marks the final pass; a single-pass build starts directly in it.
`ifdef SYNC_MAPPER_REPEAT_EN
  localparam logic START_PASS = 1'b0;
`else
  localparam logic START_PASS = 1'b1;
`endif

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [SYNC_WORD_WIDTH-1:0]    shadow_q, shadow_d;
  logic [M_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                          tvalid_q, tvalid_d;
  logic                          tlast_q, tlast_d;
  logic                          busy_q, busy_d;
  logic                          start_err_q, start_err_d;
  logic                          pass_q, pass_d;
  logic                          handshake_c;
  logic [CNT_W-1:0]              cnt_inc_c;

  function automatic logic [M_AXIS_TDATA_WIDTH-1:0] map_bit(input logic b);
    logic signed [15:0] i_val;
    i_val = b ? AMPLITUDE : -AMPLITUDE;
    return M_AXIS_TDATA_WIDTH'({16'h0000, i_val});
  endfunction

  function automatic logic carrier_bit(input logic [SYNC_WORD_WIDTH-1:0] w,
                                       input logic [CNT_W-1:0] k);
    logic [SYNC_WORD_WIDTH-1:0] s;
    s = w >> k;
    return s[0];
  endfunction

  assign handshake_c = tvalid_q & m_axis_data_tready;
  assign cnt_inc_c   = cnt_q + CNT_W'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    busy_d      = busy_q;
    start_err_d = 1'b0;
    pass_d      = pass_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (sync_word_ready) begin
            state_d  = STREAM;
            shadow_d = sync_word;
            cnt_d    = '0;
            pass_d   = START_PASS;
            tdata_d  = map_bit(sync_word[0]);
            tvalid_d = 1'b1;
            tlast_d  = (LAST_K == '0) && START_PASS;
            busy_d   = 1'b1;
          end else begin
            start_err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (handshake_c) begin
          if (cnt_q == LAST_K) begin
            if (pass_q) begin
              state_d  = DRAIN;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              tdata_d  = '0;
            end else begin
              // Second pass restarts at carrier 0 with no gap
              pass_d  = 1'b1;
              cnt_d   = '0;
              tdata_d = map_bit(shadow_q[0]);
              tlast_d = (LAST_K == '0);
            end
          end else begin
            cnt_d   = cnt_inc_c;
            tdata_d = map_bit(carrier_bit(shadow_q, cnt_inc_c));
            tlast_d = (cnt_inc_c == LAST_K) && pass_q;
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge m_axis_data_aclk or negedge m_axis_data_aresetn) begin
    if (!m_axis_data_aresetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      start_err_q <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      busy_q      <= busy_d;
      start_err_q <= start_err_d;
      pass_q      <= pass_d;
    end
  end

  assign busy               = busy_q;
  assign start_err          = start_err_q;
  assign m_axis_data_tvalid = tvalid_q;
  assign m_axis_data_tdata  = tdata_q;
  assign m_axis_data_tlast  = tlast_q;

endmodule

// File: tb/tb_sync_symbol_mapper.sv
// Bench for sync_symbol_mapper: table of symbol runs plus start-reject and mid-symbol reset sequences.
module tb_sync_symbol_mapper;

  localparam int U = 800;
`ifdef SYNC_MAPPER_REPEAT_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int BEATS = U * PASSES;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [U-1:0]  sync_word;
  logic          sync_word_ready;
  logic          start;
  logic          busy;
  logic          start_err;
  logic          tvalid;
  logic          tready;
  logic [31:0]   tdata;
  logic          tlast;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_symbol_mapper dut (
    .m_axis_data_aclk    (clk),
    .m_axis_data_aresetn (rst_n),
    .sync_word           (sync_word),
    .sync_word_ready     (sync_word_ready),
    .start               (start),
    .busy                (busy),
    .start_err           (start_err),
    .m_axis_data_tvalid  (tvalid),
    .m_axis_data_tready  (tready),
    .m_axis_data_tdata   (tdata),
    .m_axis_data_tlast   (tlast)
  );

  typedef struct {
    string        name;
    logic [U-1:0] sw;
    int           mode;       // 0: always ready, 1: toggle, 2: ready every third cycle
    int           reload_at;  // beat at which sync_word is cleared and start re-pulsed (-1: never)
    logic [31:0]  exp_b0;
    logic [31:0]  exp_b1;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [U-1:0] sw, input int k);
    return sw[k % U] ? 32'h0000_2000 : 32'h0000_E000;
  endfunction

  task automatic run_symbol(input vec_t v);
    int           beat = 0;
    int           cyc = 0;
    logic         pv = 1'b0;
    logic         phs = 1'b0;
    logic [31:0]  pd = '0;
    logic         pl = 1'b0;
    bit           reloaded = 1'b0;
    logic [U-1:0] snap;
    snap            = v.sw;
    sync_word       = v.sw;
    sync_word_ready = 1'b1;
    tready          = 1'b0;
    start           = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({v.name, "/tvalid_latency"}, 32'(tvalid), 32'd1);
    chk({v.name, "/busy_after_start"}, 32'(busy), 32'd1);
    while (beat < BEATS && cyc < 4000) begin
      start = 1'b0;
      if (v.reload_at >= 0 && beat == v.reload_at && !reloaded) begin
        sync_word = '0;
        start     = 1'b1;
        reloaded  = 1'b1;
      end
      case (v.mode)
        0:       tready = 1'b1;
        1:       tready = (cyc % 2 == 0);
        default: tready = (cyc % 3 == 2);
      endcase
      chk({v.name, "/no_start_err"}, 32'(start_err), 32'd0);
      if (pv && !phs) begin
        chk({v.name, "/stall_tvalid"}, 32'(tvalid), 32'd1);
        chk({v.name, "/stall_tdata"}, tdata, pd);
        chk({v.name, "/stall_tlast"}, 32'(tlast), 32'(pl));
      end
      if (tvalid && tready) begin
        chk({v.name, "/tdata"}, tdata, exp_data(snap, beat));
        chk({v.name, "/tlast"}, 32'(tlast), 32'(beat == BEATS - 1));
        if (beat == 0) chk({v.name, "/beat0"}, tdata, v.exp_b0);
        if (beat == 1) chk({v.name, "/beat1"}, tdata, v.exp_b1);
        beat++;
      end
      pv  = tvalid;
      phs = tvalid && tready;
      pd  = tdata;
      pl  = tlast;
      @(posedge clk); #1;
      cyc++;
    end
    start  = 1'b0;
    tready = 1'b0;
    chk({v.name, "/beat_count"}, 32'(beat), 32'(BEATS));
    chk({v.name, "/drain_tvalid"}, 32'(tvalid), 32'd0);
    chk({v.name, "/drain_busy"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk({v.name, "/idle_busy"}, 32'(busy), 32'd0);
    chk({v.name, "/idle_tvalid"}, 32'(tvalid), 32'd0);
  endtask

  initial begin
    logic [U-1:0] p0;
    logic [U-1:0] p1;
    logic [U-1:0] p3;
    int           beat;
    int           cyc;

    p0    = '1;
    p0[1] = 1'b0;
    p1    = {400{2'b10}};
    p3    = {200{4'b0011}};
    vecs[0] = '{name: "ones_bit1_zero", sw: p0, mode: 0, reload_at: -1, exp_b0: 32'h0000_2000, exp_b1: 32'h0000_E000};
    vecs[1] = '{name: "alt_toggle",     sw: p1, mode: 1, reload_at: -1, exp_b0: 32'h0000_E000, exp_b1: 32'h0000_2000};
    vecs[2] = '{name: "reload_mid",     sw: p0, mode: 0, reload_at: 10, exp_b0: 32'h0000_2000, exp_b1: 32'h0000_E000};
    vecs[3] = '{name: "pairs_slow",     sw: p3, mode: 2, reload_at: -1, exp_b0: 32'h0000_2000, exp_b1: 32'h0000_2000};

    rst_n           = 1'b0;
    sync_word       = '0;
    sync_word_ready = 1'b0;
    start           = 1'b0;
    tready          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/tvalid", 32'(tvalid), 32'd0);
    chk("reset/tlast", 32'(tlast), 32'd0);
    chk("reset/busy", 32'(busy), 32'd0);
    chk("reset/start_err", 32'(start_err), 32'd0);
    chk("reset/tdata", tdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run_symbol(vecs[i]);

    // Start rejected when the sync word is not loaded
    sync_word_ready = 1'b0;
    sync_word       = p0;
    start           = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("reject/start_err", 32'(start_err), 32'd1);
    chk("reject/tvalid", 32'(tvalid), 32'd0);
    chk("reject/busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("reject/start_err_pulse", 32'(start_err), 32'd0);
    chk("reject/tvalid_after", 32'(tvalid), 32'd0);
    chk("reject/busy_after", 32'(busy), 32'd0);

    // Reset in the middle of a symbol, then a fresh symbol
    sync_word_ready = 1'b1;
    start           = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    tready = 1'b1;
    beat   = 0;
    cyc    = 0;
    while (beat < 400 && cyc < 2000) begin
      if (tvalid && tready) beat++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("midreset/beats_before", 32'(beat), 32'd400);
    chk("midreset/tvalid_before", 32'(tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset/tvalid_async", 32'(tvalid), 32'd0);
    chk("midreset/tlast_async", 32'(tlast), 32'd0);
    chk("midreset/busy_async", 32'(busy), 32'd0);
    #1;
    rst_n  = 1'b1;
    tready = 1'b0;
    @(posedge clk); #1;
    chk("midreset/idle_tvalid", 32'(tvalid), 32'd0);
    run_symbol(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_symbol_mapper.md
Name: sync_symbol_mapper

Overview:
- Downstream consumer of the 800-bit sync word register loaded over the config AXI-Stream.
- On a start request, snapshots the sync word and emits one BPSK-mapped complex sample per used subcarrier on a master AXI-Stream.
- The output feeds the framer's IFFT-input mux, so the sync symbol is emitted ahead of payload symbols.

Parameters:
- USED_CARRIERS, 800, number of samples emitted per sync symbol; legal range 1..800.
- SYNC_WORD_WIDTH, 800, width of the sync_word input bus; must be >= USED_CARRIERS.
- AMPLITUDE, 16'sd8192, signed I magnitude for a mapped bit.
- M_AXIS_TDATA_WIDTH, 32, output width; fixed at {Q[15:0], I[15:0]}.

Ports:
- m_axis_data_aclk  in  1  sole clock.
- m_axis_data_aresetn  in  1  asynchronous active-low reset.
- sync_word  in  SYNC_WORD_WIDTH  sync word from the config stage; bit k maps to carrier k.
- sync_word_ready  in  1  high once the config stage has loaded all USED_CARRIERS bits.
- start  in  1  single-cycle request to emit one sync symbol.
- busy  out  1  high while not IDLE.
- start_err  out  1  one-cycle pulse when start is rejected because sync_word_ready=0.
- m_axis_data_tvalid  out  1  AXI-Stream valid.
- m_axis_data_tready  in  1  AXI-Stream ready.
- m_axis_data_tdata  out  32  {Q, I}, two's complement.
- m_axis_data_tlast  out  1  high on the final sample of the symbol.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State is IDLE and carrier counter is 0.
  - tvalid, tlast, busy and start_err are 0; tdata is 0.
  - The shadow register is 0.
- States are IDLE, STREAM and DRAIN.
- IDLE:
  - start=1 with sync_word_ready=1: copy sync_word into the shadow register, load carrier 0 into the output register, go to STREAM. tvalid rises the next cycle (1-cycle latency).
  - start=1 with sync_word_ready=0: pulse start_err for 1 cycle, stay in IDLE.
- STREAM:
  - The output register holds carrier index k.
  - On a handshake (tvalid & tready), k increments and the output register reloads with carrier k+1 in the same cycle, giving 1 sample/clk throughput.
  - Without tready, tvalid, tdata and tlast hold stable (AXI-Stream rule).
  - tlast=1 exactly when k = USED_CARRIERS-1.
  - A handshake with tlast=1 goes to DRAIN.
- DRAIN: tvalid=0 for exactly one cycle, then IDLE. This guarantees a 1-cycle gap between symbols.
- Mapping:
  - Shadow bit 1 gives I=+AMPLITUDE; bit 0 gives I=-AMPLITUDE.
  - Q is always 0.
  - Bit k uses the shadow register, not the live sync_word, so a config reload mid-symbol does not affect output.
- Counter is 11 bits and saturates at USED_CARRIERS-1; there is no wrap within a symbol.
- start while busy=1 is ignored, with no start_err and no state change.
- Reset mid-symbol: tvalid drops asynchronously and the symbol is abandoned; no tlast is issued.
- busy=1 from the cycle after an accepted start through the DRAIN cycle, inclusive.

Optional Feature:
- Macro: SYNC_MAPPER_REPEAT_EN.
- Defined:
  - After the last carrier, STREAM restarts at k=0 once and emits the symbol a second time back-to-back, with no gap, for Schmidl-Cox timing.
  - tlast is asserted only on the final sample of the second pass, so a symbol is 2*USED_CARRIERS beats.
  - An internal pass bit tracks the repetition.
- Undefined: single pass only, as described above.

Test Plan:
- Reset, sync_word_ready=1, sync_word bit0=1/bit1=0/else 1, start pulse, tready=1:
  - tvalid rises 1 cycle after start.
  - Beat0 tdata=0x00002000, beat1 tdata=0x0000E000.
  - 800 beats total, tlast only on beat 799; busy falls 2 cycles after the last handshake.
- tready toggled 1/0 every cycle during a symbol: tdata and tlast stable while stalled; 800 beats, order unchanged; no sample dropped or duplicated.
- start with sync_word_ready=0: start_err=1 for one cycle, tvalid stays 0, busy stays 0.
- After beat 10, drive sync_word to all zeros and pulse start again: remaining beats still follow the snapshot; second start ignored; exactly 800 beats.
- Deassert aresetn at beat 400: tvalid=0 immediately without a clock edge. After release and a new start, beat0 is carrier 0.
- With SYNC_MAPPER_REPEAT_EN, USED_CARRIERS=8, sync_word=8'b10110001:
  - 16 beats, I sequence repeated twice, tlast only on beat 15.
  - No gap between beat 7 and beat 8.
